// File: rtl/gb_joypad.sv
// gb_joypad: Game Boy P1/FF00 joypad register.
// Maps debounced button presses onto the two active-low key groups chosen by
// the CPU select bits, returns the P1 read value and pulses joypad_irq on any
// selected line falling, with a programmable hold-off after each pulse.
// Optional feature macro: JOYPAD_STICKY_EN (latches short presses until a P1 read).
module gb_joypad #(
  parameter int IRQ_HOLDOFF = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttonState,
  input  logic [2:0] extraButtons,
  input  logic       p1_we,
  input  logic [7:0] p1_wdata,
  input  logic       p1_re,
  output logic [7:0] p1_rdata,
  output logic       joypad_irq
);

  localparam int CW = ($clog2(IRQ_HOLDOFF + 1) > 1) ? $clog2(IRQ_HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'((IRQ_HOLDOFF > 0) ? IRQ_HOLDOFF - 1 : 0);

  typedef enum logic {ARMED, HOLDOFF} state_t;

  // Pressed vector order: {start, select, B, left, right, down, up, A}
  logic [7:0]    press_next;
  logic [7:0]    p;
  logic [7:0]    eff;
  logic [1:0]    sel;
  logic [3:0]    dir;
  logic [3:0]    act;
  logic [3:0]    low;
  logic [3:0]    prev_low;
  logic          fall;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          irq_next;
  logic          unused_bits;

  assign press_next = {extraButtons, buttonState[4:0]};

`ifdef JOYPAD_STICKY_EN
  logic [7:0] s;
  logic [7:0] clr;

  // A read clears sticky bits of the groups selected at that moment
  assign clr = {8{p1_re}} & {{3{~sel[1]}}, {4{~sel[0]}}, ~sel[1]};
  assign eff = p | s;
  assign unused_bits = ^{buttonState[7:5], p1_wdata[7:6], p1_wdata[3:0]};

  // Sticky bits catch press edges; a new press beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset) s <= 8'h00;
    else        s <= (s & ~clr) | (press_next & ~p);
  end
`else
  assign eff = p;
  assign unused_bits = ^{buttonState[7:5], p1_wdata[7:6], p1_wdata[3:0], p1_re};
`endif

  assign dir  = {eff[2], eff[1], eff[4], eff[3]};
  assign act  = {eff[7], eff[6], eff[5], eff[0]};
  assign low  = ~(({4{~sel[0]}} & dir) | ({4{~sel[1]}} & act));
  assign fall = |(prev_low & ~low);
  assign p1_rdata = {2'b11, sel, low};

  // Input capture, select register and previous line snapshot
  always_ff @(posedge clk) begin
    if (!reset) begin
      p        <= 8'h00;
      sel      <= 2'b11;
      prev_low <= 4'hF;
    end else begin
      p        <= press_next;
      prev_low <= low;
      if (p1_we) sel <= p1_wdata[5:4];
    end
  end

  // IRQ state register, hold-off counter and registered pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARMED;
      cnt        <= '0;
      joypad_irq <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      joypad_irq <= irq_next;
    end
  end

  // Next-state logic: fire on a fall when armed, then count out the hold-off
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    irq_next   = 1'b0;
    case (state)
      ARMED: begin
        if (fall) begin
          irq_next = 1'b1;
          if (IRQ_HOLDOFF > 0) begin
            state_next = HOLDOFF;
            cnt_next   = LOAD;
          end
        end
      end
      HOLDOFF: begin
        if (cnt == '0) state_next = ARMED;
        else           cnt_next   = cnt - CW'(1);
      end
      default: state_next = ARMED;
    endcase
  end

endmodule

// File: tb/tb_gb_joypad.sv
// Testbench for gb_joypad: two instances (hold-off 4 and hold-off 0) share
// the same stimulus and are checked every cycle against a behavioural model,
// plus hand-computed literal expectations.
module tb_gb_joypad;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buttonState;
  logic [2:0] extraButtons;
  logic       p1_we;
  logic [7:0] p1_wdata;
  logic       p1_re;
  logic [7:0] rdata4, rdata0;
  logic       irq4, irq0;

  int checks = 0;
  int errors = 0;
  int cnt4 = 0;
  int cnt0 = 0;

  always #5 clk = ~clk;

  gb_joypad #(.IRQ_HOLDOFF(HOLD)) dut (
    .clk(clk), .reset(reset), .buttonState(buttonState), .extraButtons(extraButtons),
    .p1_we(p1_we), .p1_wdata(p1_wdata), .p1_re(p1_re),
    .p1_rdata(rdata4), .joypad_irq(irq4)
  );

  gb_joypad #(.IRQ_HOLDOFF(0)) dut0 (
    .clk(clk), .reset(reset), .buttonState(buttonState), .extraButtons(extraButtons),
    .p1_we(p1_we), .p1_wdata(p1_wdata), .p1_re(p1_re),
    .p1_rdata(rdata0), .joypad_irq(irq0)
  );

  // Model: each button belongs to a group (0 = direction, 1 = action) and
  // drives one output line. Order: A, up, down, right, left, B, select, start.
  int grp[8]  = '{1, 0, 0, 0, 0, 1, 1, 1};
  int lineOf[8] = '{0, 2, 3, 0, 1, 1, 2, 3};

  logic [7:0] m_p = 8'h00;
  logic [7:0] m_s = 8'h00;
  logic [1:0] m_sel = 2'b11;
  logic [3:0] m_prev = 4'hF;
  logic       m_irq4 = 1'b0;
  logic       m_irq0 = 1'b0;
  int         edgeNum = 0;
  int         last4 = -100;
  bit         started = 1'b0;

  function automatic logic [3:0] lowOf(input logic [1:0] s, input logic [7:0] press);
    logic [3:0] l;
    l = 4'hF;
    for (int i = 0; i < 8; i++)
      if (press[i] && s[grp[i]] == 1'b0) l[lineOf[i]] = 1'b0;
    return l;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model update on every rising edge, from the inputs presented before it
  always @(posedge clk) begin
    logic [3:0] cur;
    logic [7:0] np;
    logic [7:0] clr;
    edgeNum++;
    started = 1'b1;
    if (!reset) begin
      m_p = 8'h00; m_s = 8'h00; m_sel = 2'b11; m_prev = 4'hF;
      m_irq4 = 1'b0; m_irq0 = 1'b0; last4 = -100;
    end else begin
      cur    = lowOf(m_sel, m_p | m_s);
      m_irq0 = |(m_prev & ~cur);
      m_irq4 = m_irq0 && (edgeNum - last4 >= HOLD + 1);
      if (m_irq4) last4 = edgeNum;
      m_prev = cur;
      np = {extraButtons, buttonState[4:0]};
      clr = 8'h00;
`ifdef JOYPAD_STICKY_EN
      if (p1_re)
        for (int i = 0; i < 8; i++)
          if (m_sel[grp[i]] == 1'b0) clr[i] = 1'b1;
      m_s = (m_s & ~clr) | (np & ~m_p);
`endif
      if (p1_we) m_sel = p1_wdata[5:4];
      m_p = np;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      cmp("model_rdata_h4", {24'h0, rdata4}, {24'h0, 2'b11, m_sel, lowOf(m_sel, m_p | m_s)});
      cmp("model_rdata_h0", {24'h0, rdata0}, {24'h0, 2'b11, m_sel, lowOf(m_sel, m_p | m_s)});
      cmp("model_irq_h4", {31'h0, irq4}, {31'h0, m_irq4});
      cmp("model_irq_h0", {31'h0, irq0}, {31'h0, m_irq0});
    end
  end

  task automatic tick();
    @(negedge clk);
    if (irq4 === 1'b1) cnt4++;
    if (irq0 === 1'b1) cnt0++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [2:0] e,
                               input logic w, input logic [7:0] d, input logic r);
    buttonState  = b;
    extraButtons = e;
    p1_we        = w;
    p1_wdata     = d;
    p1_re        = r;
    tick();
    p1_we = 1'b0;
    p1_re = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    cmp({name, "_h4"}, {24'h0, rdata4}, {24'h0, exp});
    cmp({name, "_h0"}, {24'h0, rdata0}, {24'h0, exp});
  endtask

  task automatic checkIrq(input string name, input int e4, input int e0);
    cmp({name, "_h4"}, cnt4, e4);
    cmp({name, "_h0"}, cnt0, e0);
    cnt4 = 0;
    cnt0 = 0;
  endtask

  initial begin
    reset = 1'b0; buttonState = 8'hFF; extraButtons = 3'b111;
    p1_we = 1'b0; p1_wdata = 8'h00; p1_re = 1'b0;
    idle(3);
    checkOutput("reset_rdata", 8'hFF);
    cmp("reset_irq", {30'h0, irq4, irq0}, 32'h0);
    reset = 1'b1;
    idle(2);
    checkOutput("post_reset_rdata", 8'hFF);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(2);
    checkIrq("no_irq_unselected", 0, 0);

    // Direction group, press up
    applyStimulus(8'h00, 3'b000, 1'b1, 8'h20, 1'b0);
    checkOutput("sel_dir", 8'hEF);
    applyStimulus(8'h02, 3'b000, 1'b0, 8'h00, 1'b0);
    checkOutput("up_pressed", 8'hEB);
    cmp("irq_not_yet", {31'h0, irq4}, 32'h0);
    idle(3);
    checkIrq("up_irq", 1, 1);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(6);

    // Action group, A and start together
    applyStimulus(8'h00, 3'b000, 1'b1, 8'h10, 1'b0);
    checkOutput("sel_act", 8'hDF);
    applyStimulus(8'h01, 3'b100, 1'b0, 8'h00, 1'b0);
    checkOutput("a_start", 8'hD6);
    idle(4);
    checkIrq("a_start_irq", 1, 1);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(8);
    checkIrq("release_no_irq", 0, 0);

    // Hold-off: quick re-press suppressed, later press accepted
    applyStimulus(8'h01, 3'b000, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h01, 3'b000, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(2);
    cmp("holdoff_first_h4", cnt4, 1);
    cmp("holdoff_first_h0", cnt0, 2);
    applyStimulus(8'h01, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(2);
    checkIrq("holdoff_second", 2, 3);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(8);

    // Fall caused by a select write
    applyStimulus(8'h00, 3'b000, 1'b1, 8'h30, 1'b0);
    applyStimulus(8'h08, 3'b000, 1'b0, 8'h00, 1'b0);
    checkOutput("right_unselected", 8'hFF);
    idle(6);
    checkIrq("right_no_irq", 0, 0);
    applyStimulus(8'h08, 3'b000, 1'b1, 8'h20, 1'b0);
    checkOutput("sel_write_fall", 8'hEE);
    idle(3);
    checkIrq("sel_write_irq", 1, 1);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(8);

    // Short B press, then P1 read
    applyStimulus(8'h00, 3'b000, 1'b1, 8'h10, 1'b0);
    applyStimulus(8'h00, 3'b001, 1'b0, 8'h00, 1'b0);
    checkOutput("b_pressed", 8'hDD);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    idle(1);
`ifdef JOYPAD_STICKY_EN
    checkOutput("b_sticky_held", 8'hDD);
`else
    checkOutput("b_released", 8'hDF);
`endif
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b1);
    checkOutput("after_read", 8'hDF);
    idle(8);
    checkIrq("b_irq", 1, 1);

    // Reset in the middle of hold-off re-arms the IRQ logic
    applyStimulus(8'h01, 3'b000, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    applyStimulus(8'h00, 3'b000, 1'b0, 8'h00, 1'b0);
    checkOutput("mid_reset", 8'hFF);
    reset = 1'b1;
    applyStimulus(8'h00, 3'b000, 1'b1, 8'h10, 1'b0);
    applyStimulus(8'h01, 3'b000, 1'b0, 8'h00, 1'b0);
    checkOutput("rearm_a", 8'hDE);
    idle(2);
    checkIrq("rearm_irq", 2, 2);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
